// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_rx_state_t : receiver FSM states
//   PS2_DATA_BITS  : data bits per frame
//   PS2_FRAME_BITS : total bits per frame (start, data, parity, stop)
//   odd_parity_ok  : 1 when data plus parity bit hold an odd number of ones
package ps2_pkg;

   localparam int unsigned PS2_DATA_BITS  = 8;
   localparam int unsigned PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_rx_state_t;

   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                          input logic                     par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: byte stream from the PS/2 receiver to its consumer.
//   rx_data  : head byte, meaningful while rx_valid is high
//   rx_valid : at least one byte buffered
//   rx_ready : consumer pops the head when rx_valid && rx_ready
//   rx_count : current occupancy
// master = receiver side, slave = consumer side.
interface ps2_rx_fifo_if #(
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [CNT_W-1:0] rx_count;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_count,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_count,
      output rx_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst : clock, synchronous active-high reset (clears pointers, count, storage)
//   push     : write wdata; accepted when not full or when a pop happens in the same cycle
//   wdata    : write data
//   pop      : remove head; ignored when empty
//   rdata    : head entry (memory[rd_ptr])
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a buffered byte output.
//   clk, rst   : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock pin (asynchronous)
//   ps2_data   : raw PS/2 data pin (asynchronous)
//   rx         : byte stream to the consumer (show-ahead FIFO, valid/ready)
//   busy       : a frame is being received
//   parity_err : one-cycle pulse, parity check failed
//   frame_err  : one-cycle pulse, stop bit low or inter-bit timeout
//   overflow   : one-cycle pulse, good byte dropped because the FIFO was full
// Frames are start(0), 8 data bits LSB first, odd parity, stop(1), sampled on
// falling edges of a glitch-filtered copy of ps2_clk.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 12500,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter bit          CHECK_PARITY   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   ps2_rx_fifo_if.master        rx,
   output logic                 busy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overflow
);

   localparam int unsigned FW = $clog2(FILTER_LEN);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BW = $clog2(PS2_DATA_BITS);

   // ---------------------------------------------------------------- synchronisers
   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_s;
   logic       data_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
      end
   end

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   // ---------------------------------------------------------------- clock filter
   logic [FW-1:0] filt_cnt_q;
   logic          clk_filt_q;
   logic          fall_q;
   logic          sample_q;
   logic          filt_flip;

   // FILTER_LEN consecutive differing samples flip the filtered clock.
   assign filt_flip = (clk_s != clk_filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_cnt_q <= '0;
         clk_filt_q <= 1'b1;
         fall_q     <= 1'b0;
         sample_q   <= 1'b1;
      end else begin
         fall_q <= filt_flip && clk_filt_q;
         if (filt_flip && clk_filt_q) begin
            sample_q <= data_s;
         end
         if ((clk_s == clk_filt_q) || filt_flip) begin
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
         if (filt_flip) begin
            clk_filt_q <= ~clk_filt_q;
         end
      end
   end

   // ---------------------------------------------------------------- receiver FSM
   ps2_rx_state_t              state_q, state_d;
   logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
   logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
   logic                       par_q, par_d;
   logic [TW-1:0]              to_cnt_q, to_cnt_d;
   logic                       timeout;
   logic                       push_req;
   logic                       push;
   logic                       perr_d, ferr_d, ovf_d;
   logic                       fifo_full;
   logic                       fifo_empty;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      to_cnt_d  = '0;
      push_req  = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      timeout   = 1'b0;

      if ((state_q != StIdle) && !fall_q) begin
         to_cnt_d = to_cnt_q + 1'b1;
         timeout  = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
      end

      unique case (state_q)
         StIdle: begin
            // A high sample here is line noise, not a start bit.
            if (fall_q && !sample_q) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (fall_q) begin
               shift_d   = {sample_q, shift_q[PS2_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
                  state_d = StParity;
               end
            end
         end
         StParity: begin
            if (fall_q) begin
               par_d   = sample_q;
               state_d = StStop;
            end
         end
         StStop: begin
            if (fall_q) begin
               state_d = StIdle;
               if (!sample_q) begin
                  ferr_d = 1'b1;
               end else if (!odd_parity_ok(shift_q, par_q)) begin
                  perr_d   = 1'b1;
                  push_req = !CHECK_PARITY;
               end else begin
                  push_req = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (timeout) begin
         state_d = StIdle;
         ferr_d  = 1'b1;
      end
   end

   // A full FIFO is never empty, so rx_ready alone means the head leaves.
   assign push  = push_req && (!fifo_full || rx.rx_ready);
   assign ovf_d = push_req && fifo_full && !rx.rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         to_cnt_q   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         parity_err <= perr_d;
         frame_err  <= ferr_d;
         overflow   <= ovf_d;
      end
   end

   assign busy = (state_q != StIdle);

   // ---------------------------------------------------------------- byte buffer
   sync_fifo #(
      .WIDTH (PS2_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (shift_q),
      .pop   (rx.rx_ready),
      .rdata (rx.rx_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (rx.rx_count)
   );

   assign rx.rx_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: two instances share the PS/2 pins and rx_ready, one
// dropping bad-parity bytes and one keeping them. A queue-based model tracks
// what each FIFO must hold and which pulses must appear, cycle by cycle.
module tb_ps2_rx_fifo;

   localparam int F     = 8;
   localparam int T     = 200;
   localparam int DEPTH = 8;
   localparam int H     = 20;   // PS/2 half period in clk cycles

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic rx_ready = 1'b0;
   logic busy_a, perr_a, ferr_a, ovf_a;
   logic busy_b, perr_b, ferr_b, ovf_b;

   always #5 clk = ~clk;

   ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_a ();
   ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_b ();
   assign rx_a.rx_ready = rx_ready;
   assign rx_b.rx_ready = rx_ready;

   ps2_rx_fifo #(
      .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(rx_a),
      .busy(busy_a), .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a)
   );

   ps2_rx_fifo #(
      .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b0)
   ) u_dut_b (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(rx_b),
      .busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b)
   );

   // ------------------------------------------------------------ checking core
   int checks = 0;
   int fails  = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------------ reference model
   typedef enum logic [1:0] {EvStart, EvEval, EvTimeout} ev_kind_t;
   typedef struct {
      int         at;
      ev_kind_t   kind;
      logic [7:0] data;
      bit         par;
      bit         stop;
   } ev_t;

   ev_t        pend[$];
   logic [7:0] mq_a[$];
   logic [7:0] mq_b[$];
   int         cyc = 0;
   bit         busy_m = 0;
   bit         ex_perr_a, ex_ferr_a, ex_ovf_a, ex_perr_b, ex_ferr_b, ex_ovf_b;
   bit         chk_en = 0;
   int         n_perr_a = 0, n_ferr_a = 0, n_ovf_a = 0, n_perr_b = 0;

   function automatic ev_t mk_ev(input int at, input ev_kind_t k, input logic [7:0] d,
                                 input bit p, input bit s);
      ev_t e;
      e.at = at; e.kind = k; e.data = d; e.par = p; e.stop = s;
      return e;
   endfunction

   // Outcome of a completed frame given the occupancy after any same-cycle pop.
   function automatic void eval_frame(input bit chkp, input int size, input ev_t e,
                                      output bit do_push, output bit perr,
                                      output bit ferr, output bit ovf);
      bit want;
      do_push = 0; perr = 0; ferr = 0; ovf = 0; want = 0;
      if (!e.stop) begin
         ferr = 1;
      end else if (($countones({e.data, e.par}) % 2) == 0) begin
         perr = 1;
         want = !chkp;
      end else begin
         want = 1;
      end
      if (want) begin
         if (size < DEPTH) do_push = 1;
         else ovf = 1;
      end
   endfunction

   ev_t m_ev;
   int  m_i;
   bit  m_psh, m_pe, m_fe, m_ov;

   always @(posedge clk) begin
      cyc = cyc + 1;
      ex_perr_a = 0; ex_ferr_a = 0; ex_ovf_a = 0;
      ex_perr_b = 0; ex_ferr_b = 0; ex_ovf_b = 0;
      if (rst) begin
         mq_a.delete(); mq_b.delete(); pend.delete();
         busy_m = 0;
      end else begin
         if (rx_ready && mq_a.size() > 0) void'(mq_a.pop_front());
         if (rx_ready && mq_b.size() > 0) void'(mq_b.pop_front());
         m_i = 0;
         while (m_i < pend.size()) begin
            if (pend[m_i].at == cyc) begin
               m_ev = pend[m_i];
               pend.delete(m_i);
               case (m_ev.kind)
                  EvStart: busy_m = 1;
                  EvTimeout: begin
                     busy_m = 0; ex_ferr_a = 1; ex_ferr_b = 1;
                  end
                  default: begin
                     busy_m = 0;
                     eval_frame(1'b1, mq_a.size(), m_ev, m_psh, m_pe, m_fe, m_ov);
                     if (m_psh) mq_a.push_back(m_ev.data);
                     ex_perr_a = m_pe; ex_ferr_a = m_fe; ex_ovf_a = m_ov;
                     eval_frame(1'b0, mq_b.size(), m_ev, m_psh, m_pe, m_fe, m_ov);
                     if (m_psh) mq_b.push_back(m_ev.data);
                     ex_perr_b = m_pe; ex_ferr_b = m_fe; ex_ovf_b = m_ov;
                  end
               endcase
            end else begin
               m_i++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid", rx_a.rx_valid, mq_a.size() != 0);
         chk("a_count", rx_a.rx_count, mq_a.size());
         if (mq_a.size() != 0) chk("a_data", rx_a.rx_data, mq_a[0]);
         chk("a_busy", busy_a, busy_m);
         chk("a_parity_err", perr_a, ex_perr_a);
         chk("a_frame_err", ferr_a, ex_ferr_a);
         chk("a_overflow", ovf_a, ex_ovf_a);
         chk("b_valid", rx_b.rx_valid, mq_b.size() != 0);
         chk("b_count", rx_b.rx_count, mq_b.size());
         if (mq_b.size() != 0) chk("b_data", rx_b.rx_data, mq_b[0]);
         chk("b_busy", busy_b, busy_m);
         chk("b_parity_err", perr_b, ex_perr_b);
         chk("b_frame_err", ferr_b, ex_ferr_b);
         chk("b_overflow", ovf_b, ex_ovf_b);
         if (perr_a === 1'b1) n_perr_a++;
         if (ferr_a === 1'b1) n_ferr_a++;
         if (ovf_a === 1'b1) n_ovf_a++;
         if (perr_b === 1'b1) n_perr_b++;
      end
   end

   // ------------------------------------------------------------ stimulus
   // The FSM acts on a pin fall F+3 clk edges after the negedge that drives it.
   task automatic send_bits(input logic [7:0] b, input bit par, input bit stop,
                            input int nbits, input bit sched_to, input bit pulse_rdy);
      logic [10:0] fr;
      int          at;
      fr = {stop, par, b, 1'b0};
      at = 0;
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         at = cyc + F + 3;
         if (i == 0) pend.push_back(mk_ev(at, EvStart, b, par, stop));
         if (i == 10) pend.push_back(mk_ev(at, EvEval, b, par, stop));
         for (int k = 0; k < H; k++) begin
            @(negedge clk);
            if (pulse_rdy && i == 10) rx_ready = (cyc == at - 1);
         end
         ps2_clk = 1'b1;
      end
      if (sched_to) pend.push_back(mk_ev(at + T, EvTimeout, b, par, stop));
      ps2_data = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_bits(b, ~^b, 1'b1, 11, 1'b0, 1'b0);
   endtask

   task automatic drain();
      @(negedge clk);
      rx_ready = 1'b1;
      repeat (DEPTH + 2) @(negedge clk);
      rx_ready = 1'b0;
   endtask

   logic [7:0] ob[10];
   bit         rnd_done;
   int         base_ferr, base_ovf;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("reset_valid", rx_a.rx_valid, 0);
      chk("reset_count", rx_a.rx_count, 0);
      chk("reset_data", rx_a.rx_data, 8'h00);
      chk("reset_busy", busy_a, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single frame
      send_good(8'h1C);
      chk("single_data", rx_a.rx_data, 8'h1C);
      chk("single_count", rx_a.rx_count, 1);
      chk("single_no_err", n_perr_a + n_ferr_a + n_ovf_a, 0);

      // Burst then consecutive pops
      send_bits(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
      send_good(8'h1C);
      chk("burst_count", rx_a.rx_count, 3);
      chk("burst_head0", rx_a.rx_data, 8'h1C);
      rx_ready = 1'b1;
      @(negedge clk); chk("burst_head1", rx_a.rx_data, 8'hF0);
      @(negedge clk); chk("burst_head2", rx_a.rx_data, 8'h1C);
      @(negedge clk); chk("burst_empty", rx_a.rx_valid, 0);
      rx_ready = 1'b0;

      // Bad parity, bad stop
      send_bits(8'h29, 1'b1, 1'b1, 11, 1'b0, 1'b0);
      chk("perr_count_a", rx_a.rx_count, 0);
      chk("perr_pulses_a", n_perr_a, 1);
      chk("perr_pulses_b", n_perr_b, 1);
      chk("perr_kept_b", rx_b.rx_data, 8'h29);
      chk("perr_count_b", rx_b.rx_count, 1);
      send_bits(8'h5A, 1'b1, 1'b0, 11, 1'b0, 1'b0);
      chk("stop_count_a", rx_a.rx_count, 0);
      chk("stop_ferr_a", n_ferr_a, 1);
      drain();

      // Glitch on ps2_clk
      @(negedge clk); ps2_clk = 1'b0;
      repeat (3) @(negedge clk); ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_busy", busy_a, 0);
      chk("glitch_ferr", n_ferr_a, 1);

      // Start + 4 data bits then silence
      send_bits(8'h0F, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      repeat (T + 40) @(negedge clk);
      chk("timeout_ferr", n_ferr_a, 2);
      chk("timeout_busy", busy_a, 0);
      send_good(8'h1C);
      chk("after_to_data", rx_a.rx_data, 8'h1C);
      chk("after_to_count", rx_a.rx_count, 1);
      drain();

      // Overflow: 9 frames, no pops
      base_ovf = n_ovf_a;
      for (int i = 0; i < 10; i++) ob[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) send_good(ob[i]);
      chk("ovf_count", rx_a.rx_count, 8);
      chk("ovf_pulses", n_ovf_a - base_ovf, 1);
      chk("ovf_head", rx_a.rx_data, ob[0]);
      // Full with pop in the push cycle
      send_bits(ob[9], ~^ob[9], 1'b1, 11, 1'b0, 1'b1);
      chk("fullpop_count", rx_a.rx_count, 8);
      chk("fullpop_pulses", n_ovf_a - base_ovf, 1);
      chk("fullpop_head", rx_a.rx_data, ob[1]);
      drain();

      // Reset mid-frame with two bytes queued
      send_good(8'h11);
      send_good(8'h22);
      send_bits(8'h77, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rst_mid_valid", rx_a.rx_valid, 0);
      chk("rst_mid_count", rx_a.rx_count, 0);
      chk("rst_mid_data", rx_a.rx_data, 8'h00);
      chk("rst_mid_busy", busy_a, 0);
      repeat (5) @(negedge clk);
      send_good(8'h32);
      chk("rst_after_data", rx_a.rx_data, 8'h32);
      chk("rst_after_count", rx_a.rx_count, 1);
      drain();

      // Randomised frames with random consumer back-pressure
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               logic [7:0] b;
               int         r;
               b = 8'($urandom);
               r = $urandom_range(0, 5);
               send_bits(b, (r == 0) ? (^b) : (~^b), (r != 1), 11, 1'b0, 1'b0);
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               rx_ready = ($urandom_range(0, 3) == 0);
            end
         end
      join
      rx_ready = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that recovers 11-bit frames (start, 8 data LSB-first, odd parity, stop) from the keyboard pins and buffers the decoded scan codes. It adds a clock glitch filter, parity and stop checking, and an inter-bit timeout. Accepted bytes go into a show-ahead FIFO with a valid/ready handshake. It sits between the PS/2 pins and `data_control`, replacing the single-byte strobe interface of `ps2_controller` so that bursts of make/break codes are not lost while Morse output is busy.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes (≥2).
- `TIMEOUT_CYCLES`, 12500: `clk` cycles allowed between filtered falling edges inside a frame. 250 µs at 50 MHz.
- `FIFO_DEPTH`, 8: number of buffered bytes. Power of two, ≥2.
- `CHECK_PARITY`, 1: 1 = drop bytes with bad parity; 0 = report `parity_err` but still push the byte.

- `clk`  in  1  system clock (50 MHz nominal).
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous. Receive-only.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `rx_data`  out  8  FIFO head byte. Valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid && rx_ready`.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  receiver FSM not in IDLE.
- `parity_err`  out  1  one-cycle pulse.
- `frame_err`  out  1  one-cycle pulse: bad stop bit or timeout.
- `overflow`  out  1  one-cycle pulse: valid byte dropped because the FIFO was full.

## Operation
- **Synchronisation:** both pins pass through 2-flop synchronisers, reset value 1.
- **Clock filter:**
  - Counter runs while the synchronised clock differs from `clk_filt` and clears otherwise.
  - When the counter reaches `FILTER_LEN-1`, `clk_filt` toggles.
  - A falling edge of `clk_filt` produces a one-cycle `fall` strobe. `ps2_data` (synchronised) is sampled on that strobe.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: `fall` with data=0 → DATA, bit counter cleared. `fall` with data=1 is ignored, no error.
  - DATA: each `fall` shifts the sample into bit[7] of the shift register (a right shift, so bits arrive LSB-first). After the 8th sample → PARITY.
  - PARITY: latch the sample. Parity is OK when the count of ones across the 8 data bits plus the parity bit is odd. → STOP.
  - STOP: on `fall`, evaluate the frame, then → IDLE.
- **Frame evaluation (STOP sample), in priority order:**
  1. stop=0 → `frame_err`; drop the byte.
  2. Bad parity → `parity_err`; drop the byte if `CHECK_PARITY`=1.
  3. Otherwise, if the FIFO has room → push. If the FIFO is full → `overflow`; drop the byte.
- **Timeout:** outside IDLE, a counter increments every cycle and clears on `fall`. Reaching `TIMEOUT_CYCLES` → `frame_err` pulse, → IDLE, and the partial byte is discarded.
- **FIFO:**
  - Show-ahead: `rx_data` = memory[rd_ptr]. Pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle: both occur and `rx_count` is unchanged.
  - Push when full with a simultaneous pop: accepted, no overflow.
  - Pop when empty: ignored.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_count`=0, `busy`=0, all error pulses 0. Pointers and filter state cleared, `clk_filt`=1, FSM in IDLE.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. Frame detection resumes at the next start bit.
- `fall` asserts 2+`FILTER_LEN` cycles after the raw `ps2_clk` fall is first captured. The raw pin must be stable for that whole interval.
- FIFO write happens on the clock edge that ends the cycle in which the STOP `fall` is seen. `rx_valid` and `rx_count` update in the following cycle.
- Error pulses are asserted in the cycle after the triggering `fall` or timeout.
- Pop: `rx_data` shows the next entry in the cycle after the `rx_valid && rx_ready` edge.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_rx_state_t` (IDLE/DATA/PARITY/STOP);
  - `PS2_DATA_BITS`=8;
  - `PS2_FRAME_BITS`=11.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count; show-ahead). Reused by `data_control`.
- Synchronisers, filter and FSM stay in the top block.

## Test plan
- **Single frame:** send frame 0x1C (parity 0, stop 1), `rx_ready`=0 → `rx_valid`=1, `rx_data`=0x1C, `rx_count`=1, no error pulses.
- **Back-to-back burst:** frames 0x1C, 0xF0 (parity 1), 0x1C, `rx_ready`=0 → `rx_count`=3. Then hold `rx_ready`=1 → pops return 0x1C, 0xF0, 0x1C on consecutive cycles, then `rx_valid`=0.
- **Bad parity and bad stop:** send 0x29 with parity 1 → `parity_err` pulse and `rx_count` stays 0. Send 0x5A with stop 0 → `frame_err` pulse and nothing pushed. With `CHECK_PARITY`=0, the 0x29 byte is pushed and `parity_err` still pulses.
- **Glitch and timeout:**
  - A 3-cycle low glitch on `ps2_clk` (`FILTER_LEN`=8) → no `fall`, FSM stays in IDLE.
  - Start bit plus 4 data bits, then silence → `frame_err` exactly `TIMEOUT_CYCLES` after the last `fall`, `busy`=0.
  - A following good 0x1C frame is received correctly.
- **Overflow and boundaries:**
  - Send 9 frames with `FIFO_DEPTH`=8 and no pops → `rx_count`=8, one `overflow` pulse, and the head is still the first byte.
  - With the FIFO full, pulse `rx_ready` in the same cycle as a push → push accepted, `rx_count` stays 8, no overflow.
- **Reset mid-frame:** assert `rst` for 1 cycle after 5 bits of a frame, with 2 bytes queued → all outputs at reset values next cycle. The next full 0x32 frame yields `rx_data`=0x32, `rx_count`=1.
